// File: rtl/mem_resp_demux_if.sv
// Request/response bundle between a memory front-end and the IR/MDR demux.
// The master side issues reads and consumes the registered IR/MDR results.
interface mem_resp_demux_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic             req_sel;
  logic             req_ready;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             flush;
  logic [WIDTH-1:0] ir_q;
  logic             ir_load;
  logic [WIDTH-1:0] mdr_q;
  logic             mdr_load;
  logic [CW-1:0]    outstanding;
  logic             err;

  modport master (
    output req_valid, req_sel, rsp_valid, rsp_data, flush,
    input  req_ready, ir_q, ir_load, mdr_q, mdr_load, outstanding, err
  );

  modport slave (
    input  req_valid, req_sel, rsp_valid, rsp_data, flush,
    output req_ready, ir_q, ir_load, mdr_q, mdr_load, outstanding, err
  );
endinterface

// File: rtl/mem_resp_demux.sv
// Routes in-order memory read responses to IR or MDR using a tag FIFO;
// a flush turns pending tags into a drop count so stale responses are discarded.
module mem_resp_demux #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_resp_demux_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    count_reg, count_next;
  logic [CW-1:0]    drop_reg, drop_next;
  logic [DEPTH-1:0] tag_reg, tag_next;
  logic [WIDTH-1:0] ir_reg, ir_next;
  logic [WIDTH-1:0] mdr_reg, mdr_next;
  logic             ir_load_reg, ir_load_next;
  logic             mdr_load_reg, mdr_load_next;
  logic             err_reg, err_next;

  logic [CW-1:0]    occupancy;
  logic             ready;
  logic             push;
  logic             rsp_drop;
  logic             rsp_pop;
  logic             rsp_unexp;
  logic             consumed;
  logic [CW-1:0]    push_slot;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg    <= '0;
      drop_reg     <= '0;
      tag_reg      <= '0;
      ir_reg       <= '0;
      mdr_reg      <= '0;
      ir_load_reg  <= 1'b0;
      mdr_load_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      count_reg    <= count_next;
      drop_reg     <= drop_next;
      tag_reg      <= tag_next;
      ir_reg       <= ir_next;
      mdr_reg      <= mdr_next;
      ir_load_reg  <= ir_load_next;
      mdr_load_reg <= mdr_load_next;
      err_reg      <= err_next;
    end
  end

  // Next-state logic; stale (dropped) responses take priority over live tags.
  always_comb begin
    push      = bus.req_valid && ready;
    rsp_drop  = bus.rsp_valid && (drop_reg != '0);
    rsp_pop   = bus.rsp_valid && (drop_reg == '0) && (count_reg != '0);
    rsp_unexp = bus.rsp_valid && (drop_reg == '0) && (count_reg == '0);
    consumed  = rsp_drop || rsp_pop;
    push_slot = count_reg - CW'(rsp_pop);

    if (bus.flush) begin
      count_next = '0;
      drop_next  = drop_reg + count_reg - CW'(consumed);
    end else begin
      count_next = count_reg + CW'(push) - CW'(rsp_pop);
      drop_next  = drop_reg - CW'(rsp_drop);
    end

    ir_load_next  = rsp_pop && !tag_reg[0];
    mdr_load_next = rsp_pop && tag_reg[0];
    ir_next       = ir_load_next ? bus.rsp_data : ir_reg;
    mdr_next      = mdr_load_next ? bus.rsp_data : mdr_reg;
    err_next      = err_reg || rsp_unexp;
  end

  // Tag FIFO as a shift register: head at entry 0, new tag lands behind the
  // last live entry after any same-edge pop.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tag
      logic shifted;
      if (gi == DEPTH - 1) begin : g_last
        assign shifted = rsp_pop ? 1'b0 : tag_reg[gi];
      end else begin : g_mid
        assign shifted = rsp_pop ? tag_reg[gi+1] : tag_reg[gi];
      end
      assign tag_next[gi] = bus.flush ? 1'b0 :
                            (push && (push_slot == CW'(gi))) ? bus.req_sel : shifted;
    end
  endgenerate

  // Outputs
  always_comb begin
    occupancy = count_reg + drop_reg;
    ready     = (occupancy < CW'(DEPTH)) && !bus.flush;
  end

  assign bus.req_ready   = ready;
  assign bus.outstanding = occupancy;
  assign bus.ir_q        = ir_reg;
  assign bus.ir_load     = ir_load_reg;
  assign bus.mdr_q       = mdr_reg;
  assign bus.mdr_load    = mdr_load_reg;
  assign bus.err         = err_reg;
endmodule
